exc_redirect: RTL and testbench

Sits directly downstream of the CP0 block. Consumes its exception pulse (exc), exception-return indication (back) and EPC, and turns them into pipeline flush signals and a held PC-redirect request to the AXI instruction-fetch unit. A small FSM keeps the redirect asserted until fetch accepts it, then discards stale in-flight fetch returns for a programmable number of cycles.

---
 rtl/exc_redirect_if.sv | 32 +++
 rtl/exc_redirect.sv | 113 +++++++++++
 tb/tb_exc_redirect.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/exc_redirect_if.sv
// CP0-facing event inputs and fetch/pipeline-facing redirect and flush outputs of exc_redirect.
// The slave modport is the redirect block; master is whoever drives CP0 events and consumes flushes.
interface exc_redirect_if #(
    parameter int unsigned CNT_W = 16
);
    logic [1:0]       exc;
    logic             back;
    logic [31:0]      epc;
    logic             redirect_ready;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush_if;
    logic             flush_id;
    logic             flush_ex;
    logic             flush_mem;
    logic             stall_pipe;
    logic             in_bd;
    logic [CNT_W-1:0] exc_count;
    logic [CNT_W-1:0] eret_count;

    modport slave (
        input  exc, back, epc, redirect_ready,
        output redirect_valid, redirect_pc, flush_if, flush_id, flush_ex, flush_mem,
               stall_pipe, in_bd, exc_count, eret_count
    );

    modport master (
        output exc, back, epc, redirect_ready,
        input  redirect_valid, redirect_pc, flush_if, flush_id, flush_ex, flush_mem,
               stall_pipe, in_bd, exc_count, eret_count
    );
endinterface

// File: rtl/exc_redirect.sv
// Turns CP0 exception/ERET events into pipeline flushes and a held PC redirect to instruction fetch,
// then keeps IF flushed for SETTLE_CYCLES cycles so stale fetch returns are dropped.
module exc_redirect #(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input logic            clk,
    input logic            resetn,
    exc_redirect_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_e           state_q;
    logic [3:0]       settle_q;
    logic             valid_q;
    logic             stall_q;
    logic             flush_if_q;
    logic             flush_rest_q;
    logic             in_bd_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] exc_cnt_q;
    logic [CNT_W-1:0] eret_cnt_q;
    logic [CNT_W-1:0] exc_cnt_d;
    logic [CNT_W-1:0] eret_cnt_d;
    logic             evt_exc;
    logic             evt_eret;

    // Exception wins over a simultaneous ERET; exc==3 is handled like a plain exception.
    assign evt_exc    = (bus.exc != 2'd0);
    assign evt_eret   = bus.back & ~evt_exc;
    assign exc_cnt_d  = exc_cnt_q + 1'b1;
    assign eret_cnt_d = eret_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            settle_q     <= 4'd0;
            valid_q      <= 1'b0;
            stall_q      <= 1'b0;
            flush_if_q   <= 1'b0;
            flush_rest_q <= 1'b0;
            in_bd_q      <= 1'b0;
            pc_q         <= 32'd0;
            exc_cnt_q    <= '0;
            eret_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (evt_exc || evt_eret) begin
                        valid_q      <= 1'b1;
                        stall_q      <= 1'b1;
                        flush_if_q   <= 1'b1;
                        flush_rest_q <= 1'b1;
                        state_q      <= REQ;
                    end
                    if (evt_exc) begin
                        pc_q      <= EXC_VECTOR;
                        in_bd_q   <= (bus.exc == 2'd2);
                        exc_cnt_q <= exc_cnt_d;
                    end else if (evt_eret) begin
                        pc_q       <= bus.epc;
                        eret_cnt_q <= eret_cnt_d;
                    end
                end
                REQ: begin
                    flush_rest_q <= 1'b0;
                    if (bus.redirect_ready && valid_q) begin
                        valid_q  <= 1'b0;
                        stall_q  <= 1'b0;
                        settle_q <= SETTLE_LD;
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    // The <=1 test also drains a zero count rather than wrapping.
                    if (settle_q <= 4'd1) begin
                        flush_if_q <= 1'b0;
                        settle_q   <= 4'd0;
                        state_q    <= IDLE;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    settle_q     <= 4'd0;
                    valid_q      <= 1'b0;
                    stall_q      <= 1'b0;
                    flush_if_q   <= 1'b0;
                    flush_rest_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.redirect_valid = valid_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.flush_if       = flush_if_q;
    assign bus.flush_id       = flush_rest_q;
    assign bus.flush_ex       = flush_rest_q;
    assign bus.flush_mem      = flush_rest_q;
    assign bus.stall_pipe     = stall_q;
    assign bus.in_bd          = in_bd_q;
    assign bus.exc_count      = exc_cnt_q;
    assign bus.eret_count     = eret_cnt_q;
endmodule

// File: tb/tb_exc_redirect.sv
// Bench for exc_redirect: directed scenarios plus randomized traffic checked every cycle
// against a behavioural model of the redirect/settle protocol.
module tb_exc_redirect;
    localparam logic [31:0] VEC    = 32'hBFC00380;
    localparam int          SETTLE = 2;
    localparam int          CW     = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    exc_redirect_if #(.CNT_W(CW)) bus();

    exc_redirect #(
        .EXC_VECTOR   (VEC),
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (CW)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: a redirect is either pending, or IF is still draining for m_settle cycles, or idle.
    bit          m_pend;
    bit          m_first;
    int          m_settle;
    logic [31:0] m_pc;
    bit          m_bd;
    int          m_exc;
    int          m_eret;

    task automatic model_reset();
        m_pend = 0; m_first = 0; m_settle = 0; m_pc = 32'd0; m_bd = 0; m_exc = 0; m_eret = 0;
    endtask

    task automatic model_step();
        bit is_exc;
        bit is_eret;
        is_exc  = (bus.exc != 2'd0);
        is_eret = bus.back && !is_exc;
        if (m_pend) begin
            m_first = 0;
            if (bus.redirect_ready) begin
                m_pend   = 0;
                m_settle = SETTLE;
            end
        end else if (m_settle > 0) begin
            m_settle--;
        end else if (is_exc) begin
            m_pend = 1; m_first = 1; m_pc = VEC; m_bd = (bus.exc == 2'd2); m_exc++;
        end else if (is_eret) begin
            m_pend = 1; m_first = 1; m_pc = bus.epc; m_eret++;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"},  32'(bus.redirect_valid), 32'(m_pend));
        chk({tag, ".stall"},  32'(bus.stall_pipe), 32'(m_pend));
        chk({tag, ".pc"},     bus.redirect_pc, m_pc);
        chk({tag, ".fl_if"},  32'(bus.flush_if), 32'(m_pend || (m_settle > 0)));
        chk({tag, ".fl_rest"}, 32'({bus.flush_id, bus.flush_ex, bus.flush_mem}), 32'({3{m_first}}));
        chk({tag, ".in_bd"},  32'(bus.in_bd), 32'(m_bd));
        chk({tag, ".exc_cnt"},  32'(bus.exc_count), 32'(m_exc % (1 << CW)));
        chk({tag, ".eret_cnt"}, 32'(bus.eret_count), 32'(m_eret % (1 << CW)));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (resetn) model_step(); else model_reset();
        #1;
        compare_all(tag);
    endtask

    task automatic set_in(input logic [1:0] e, input logic b, input logic [31:0] pc, input logic rdy);
        bus.exc = e; bus.back = b; bus.epc = pc; bus.redirect_ready = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        set_in(2'd0, 1'b0, bus.epc, rdy);
        for (int i = 0; i < n; i++) cycle("idle");
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        #2 resetn = 1'b0;
        #1 model_reset();
        compare_all(tag);
        cycle({tag, "_held"});
        resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        set_in(2'd0, 1'b0, 32'd0, 1'b0);
        #1 compare_all("por");
        cycle("por_hold");
        resetn = 1'b1;
        idle(2, 1'b0);

        // Exception, fetch stalls three cycles before accepting.
        set_in(2'd1, 1'b0, 32'h1234_5678, 1'b0);
        cycle("s1_evt");
        chk("s1_pc", bus.redirect_pc, VEC);
        chk("s1_flush", 32'({bus.flush_if, bus.flush_id, bus.flush_ex, bus.flush_mem}), 32'hF);
        set_in(2'd0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("s1_wait");
        bus.redirect_ready = 1'b1;
        cycle("s1_acc");
        chk("s1_valid_drop", 32'(bus.redirect_valid), 32'd0);
        bus.redirect_ready = 1'b0;
        idle(4, 1'b0);
        chk("s1_exc_count", 32'(bus.exc_count), 32'd1);

        // ERET with fetch always ready.
        set_in(2'd0, 1'b1, 32'hBFC00100, 1'b1);
        cycle("s2_evt");
        chk("s2_pc", bus.redirect_pc, 32'hBFC00100);
        set_in(2'd0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        cycle("s2_acc");
        chk("s2_valid_once", 32'(bus.redirect_valid), 32'd0);
        idle(4, 1'b1);
        chk("s2_eret_count", 32'(bus.eret_count), 32'd1);

        // Delay-slot exception colliding with ERET.
        set_in(2'd2, 1'b1, 32'h0000_0040, 1'b0);
        cycle("s3_evt");
        chk("s3_pc", bus.redirect_pc, VEC);
        chk("s3_bd", 32'(bus.in_bd), 32'd1);
        chk("s3_eret", 32'(bus.eret_count), 32'd1);
        set_in(2'd1, 1'b0, 32'd0, 1'b0);
        cycle("s4_spur_req");
        set_in(2'd3, 1'b1, 32'h0000_0080, 1'b1);
        cycle("s4_acc");
        set_in(2'd0, 1'b1, 32'h0000_00C0, 1'b0);
        cycle("s4_spur_settle");
        cycle("s4_spur_settle2");
        set_in(2'd0, 1'b0, 32'd0, 1'b0);
        idle(2, 1'b0);
        chk("s4_exc_count", 32'(bus.exc_count), 32'd2);

        // Reset while a redirect is pending.
        set_in(2'd1, 1'b0, 32'd0, 1'b0);
        cycle("s5_evt");
        set_in(2'd0, 1'b0, 32'd0, 1'b0);
        cycle("s5_req");
        async_reset("s5_arst");
        chk("s5_valid0", 32'(bus.redirect_valid), 32'd0);
        chk("s5_pc0", bus.redirect_pc, 32'd0);
        set_in(2'd1, 1'b0, 32'd0, 1'b1);
        cycle("s5_again");
        chk("s5_again_pc", bus.redirect_pc, VEC);
        idle(4, 1'b1);

        // Sixteen accepted exceptions wrap the 4-bit counter; ERET target sampled only once.
        async_reset("s6_rst");
        for (int k = 0; k < 16; k++) begin
            set_in(2'd1, 1'b0, 32'd0, 1'b1);
            cycle("s6_evt");
            idle(3, 1'b1);
        end
        chk("s6_wrap", 32'(bus.exc_count), 32'd0);
        set_in(2'd0, 1'b1, 32'hA000_0010, 1'b0);
        cycle("s6_eret");
        for (int i = 0; i < 3; i++) begin
            set_in(2'd0, 1'b0, $urandom, 1'b0);
            cycle("s6_epc_chg");
        end
        chk("s6_pc_held", bus.redirect_pc, 32'hA000_0010);
        idle(4, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'd0,
                   1'($urandom_range(0, 4) == 0), $urandom, 1'($urandom_range(0, 2) == 0));
            cycle("rnd");
            if ($urandom_range(0, 399) == 0) async_reset("rnd_arst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
